// File: rtl/seq_serializer_if.sv
// Upstream word handshake for the serializer: the producer (master) offers a
// word with data_valid, and the serializer (slave) takes it when data_ready is high.
interface seq_serializer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the serial sequence detector.
// A one-word holding register sits in front of the shifter, so a new word can
// be loaded on the same edge that the last bit of the current word retires.
// As a result, back-to-back words stream with no idle bit between them.
module seq_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    seq_serializer_if.slave    up,
    output logic               seq_out,
    output logic               seq_valid,
    output logic               busy,
    output logic [15:0]        words_sent
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        words_q, words_d;

    logic               cur_bit;
    logic [WIDTH-1:0]   sh_shifted;
    logic               accept;

    // Shift direction only changes which end of sh is presented and
    // which way the register moves.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign cur_bit    = sh_q[WIDTH-1];
            assign sh_shifted = {sh_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign cur_bit    = sh_q[0];
            assign sh_shifted = {1'b0, sh_q[WIDTH-1:1]};
        end
    endgenerate

    // data_ready depends only on registered state (and reset), never on data_valid.
    assign up.data_ready = !hold_full_q && !rst;
    assign accept        = up.data_valid && up.data_ready;

    assign seq_valid  = (state_q == SHIFT);
    assign seq_out    = (state_q == SHIFT) ? cur_bit : IDLE_BIT;
    assign busy       = (state_q == SHIFT) || hold_full_q;
    assign words_sent = words_q;

    // Next-state logic: accept into hold, load the shifter, advance bits, count words.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        words_d     = words_q;

        // Accept and load never coincide: accept needs hold empty, load needs it full.
        if (accept) begin
            hold_d      = up.data_in;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    sh_d        = hold_q;
                    cnt_d       = '0;
                    hold_full_d = 1'b0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    words_d = words_q + 16'd1;
                    if (hold_full_q) begin
                        sh_d        = hold_q;
                        cnt_d       = '0;
                        hold_full_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    sh_d  = sh_shifted;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers. Reset discards any held or partly shifted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sh_q        <= '0;
            cnt_q       <= '0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            words_q     <= words_d;
        end
    end
endmodule
